// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Largest supported buffer / outstanding-read depth; storage is sized to this.
  localparam int unsigned MAX_DEPTH = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Slot index into a MAX_DEPTH-entry array.
  typedef logic [1:0] slot_t;

  // Occupancy / credit counter, 0..MAX_DEPTH.
  typedef logic [2:0] cnt_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Ring-pointer increment that wraps at the configured depth (need not be a power of two).
  function automatic slot_t slot_inc(input slot_t s, input int unsigned depth);
    return (s == slot_t'(depth - 1)) ? '0 : s + slot_t'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: small synchronous FIFO of {pc, instr} entries with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output cnt_t         count
);

  fetch_entry_t mem [MAX_DEPTH];
  slot_t        wr_ptr;
  slot_t        rd_ptr;
  cnt_t         count_q;

  // Pointer and occupancy bookkeeping; flush overrides a same-cycle push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= slot_inc(wr_ptr, DEPTH);
      end
      if (pop) begin
        rd_ptr <= slot_inc(rd_ptr, DEPTH);
      end
      count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Entry storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited sequential fetch with in-order
// responses, an instruction buffer, and redirect with stale-response discard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  fetch_pc;
  cnt_t         outstanding;
  cnt_t         outstanding_d;
  cnt_t         discard_cnt;
  cnt_t         discard_d;
  cnt_t         occupancy;
  cnt_t         fifo_count;
  logic [31:0]  pcq [MAX_DEPTH];
  slot_t        pcq_wr;
  slot_t        pcq_rd;
  fetch_entry_t fifo_head;
  fetch_entry_t push_entry;
  logic         rsp;
  logic         keep;
  logic         accept;
  logic         pop;

  // Request credit, response classification and outstanding-count update.
  always_comb begin
    occupancy     = outstanding + fifo_count;
    rsp           = mem_rvalid && (outstanding != '0);
    keep          = rsp && (discard_cnt == '0);
    mem_req       = !reset && (state_q == RUN) && !redirect_valid && (occupancy < DEPTH_CNT);
    accept        = mem_req && mem_gnt;
    pop           = instr_valid && instr_ready && !redirect_valid;
    outstanding_d = outstanding + cnt_t'(accept) - cnt_t'(rsp);
    push_entry.pc    = pcq[pcq_rd];
    push_entry.instr = mem_rdata;
  end

  // Next state and discard count; redirect takes priority over everything else.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_cnt;
    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old stream.
      discard_d = outstanding_d;
      state_d   = (outstanding_d != '0) ? DRAIN : RUN;
    end else begin
      if (rsp && (discard_cnt != '0)) begin
        discard_d = discard_cnt - cnt_t'(1);
      end
      if ((state_q == DRAIN) && (discard_cnt == '0)) begin
        state_d = RUN;
      end
    end
  end

  // State, counters and fetch address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      state_q     <= state_d;
      outstanding <= outstanding_d;
      discard_cnt <= discard_d;
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
      end else if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  // Issue-pc queue pointers: one entry per outstanding read, retired in order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else begin
      if (accept) begin
        pcq_wr <= slot_inc(pcq_wr, DEPTH);
      end
      if (rsp) begin
        pcq_rd <= slot_inc(pcq_rd, DEPTH);
      end
    end
  end

  // Issue-pc storage; written on accept, only read while its read is outstanding.
  always_ff @(posedge clk) begin
    if (accept) begin
      pcq[pcq_wr] <= fetch_pc;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (keep),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign mem_addr    = fetch_pc;
  assign instr_valid = (fifo_count != '0);
  assign instruction = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int unsigned DEPTH      = 2;
  localparam logic [31:0] A_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] B_RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_gnt, mem_rvalid, instr_valid, instr_ready, redirect_valid;
  logic [31:0] mem_addr, mem_rdata, instruction, instr_pc, redirect_pc;
  logic        mem_req_b, mem_gnt_b, mem_rvalid_b, instr_valid_b, instr_ready_b, redirect_valid_b;
  logic [31:0] mem_addr_b, mem_rdata_b, instruction_b, instr_pc_b, redirect_pc_b;

  fetch_unit #(.RESET_PC(A_RESET_PC), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_PC(B_RESET_PC), .DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .reset(reset),
    .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_gnt(mem_gnt_b),
    .mem_rvalid(mem_rvalid_b), .mem_rdata(mem_rdata_b),
    .instr_valid(instr_valid_b), .instruction(instruction_b), .instr_pc(instr_pc_b),
    .instr_ready(instr_ready_b), .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mreq_t       memq[$];
  exp_t        expq[$];
  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];
  int unsigned checks, failures, cyc, epoch, lat_min, lat_max, last_due, b_n;
  logic [31:0] m_fetch_pc, data_key, prev_addr, b_exp, b_pend_addr;
  bit          prev_stall, spurious_en, last_req, b_pend, last_redir, done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic tick(input bit gnt, input bit ready, input bit redir, input logic [31:0] rpc);
    bit          resp_now;
    bit          old_pending;
    mreq_t       e;
    int unsigned due;
    @(negedge clk);
    mem_gnt        = gnt;
    instr_ready    = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    resp_now = (memq.size() != 0) && (memq[0].due <= cyc);
    if (resp_now) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memq[0].addr ^ data_key;
    end else begin
      mem_rvalid = spurious_en && (memq.size() == 0) && ($urandom_range(0, 15) == 0);
      mem_rdata  = $urandom;
    end
    mem_gnt_b    = 1'b1;
    mem_rvalid_b = b_pend;
    mem_rdata_b  = b_pend_addr;
    #1;
    check_eq("instr_valid", instr_valid, expq.size() != 0);
    if (instr_valid && expq.size() != 0) begin
      check_eq("instr_pc", instr_pc, expq[0].pc);
      check_eq("instruction", instruction, expq[0].instr);
    end
    old_pending = 1'b0;
    foreach (memq[i]) if (memq[i].epoch != epoch) old_pending = 1'b1;
    if (redir || old_pending) check_eq("req_blocked", mem_req, 1'b0);
    if (mem_req) begin
      check_eq("mem_addr", mem_addr, m_fetch_pc);
      check_eq("credit", (memq.size() + expq.size()) < DEPTH, 1'b1);
    end
    if (prev_stall && mem_req) check_eq("addr_hold", mem_addr, prev_addr);
    if (instr_valid && ready && !redir && expq.size() != 0) begin
      del_log.push_back(expq[0].pc);
      expq.delete(0);
    end
    if (redir) begin
      epoch++;
      expq.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
    end
    if (resp_now) begin
      e = memq.pop_front();
      if (e.epoch == epoch) expq.push_back('{e.addr, e.addr ^ data_key});
    end
    if (mem_req && gnt) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due < last_due) due = last_due;
      last_due = due;
      memq.push_back('{m_fetch_pc, due, epoch});
      acc_log.push_back(m_fetch_pc);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    prev_stall = mem_req && !gnt;
    prev_addr  = mem_addr;
    last_req   = mem_req;
    if (instr_valid_b) begin
      check_eq("b_instr_pc", instr_pc_b, b_exp);
      check_eq("b_instruction", instruction_b, b_exp);
      b_exp = b_exp + 32'd4;
      b_n++;
    end
    b_pend      = mem_req_b;
    b_pend_addr = mem_addr_b;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    mem_gnt_b      = 1'b0;
    mem_rvalid_b   = 1'b0;
    #1;
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_instr_valid", instr_valid, 1'b0);
    check_eq("rst_instruction", instruction, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    check_eq("rst_mem_addr", mem_addr, A_RESET_PC);
    check_eq("rst_b_mem_addr", mem_addr_b, B_RESET_PC);
    check_eq("rst_b_instr_valid", instr_valid_b, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    memq.delete();
    expq.delete();
    acc_log.delete();
    del_log.delete();
    epoch       = 0;
    last_due    = 0;
    m_fetch_pc  = A_RESET_PC;
    prev_stall  = 1'b0;
    b_pend      = 1'b0;
    b_exp       = B_RESET_PC;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    mem_gnt_b = 1'b0; mem_rvalid_b = 1'b0; mem_rdata_b = '0; instr_ready_b = 1'b1;
    redirect_valid_b = 1'b0; redirect_pc_b = '0;
    checks = 0; failures = 0; cyc = 0; b_n = 0;
    data_key = '0; lat_min = 1; lat_max = 1; spurious_en = 1'b0;

    // Sequential streaming with a 1-cycle memory returning the address as data.
    do_reset();
    tick(1'b1, 1'b1, 1'b0, '0);
    check_eq("first_req", last_req, 1'b1);
    tick(1'b1, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 1'b0, '0);
    check_eq("startup_deliveries", del_log.size(), 1);
    repeat (20) tick(1'b1, 1'b1, 1'b0, '0);
    check_eq("stream_progress", del_log.size() >= 8, 1'b1);

    // Consumer stalled: buffer fills, requests stop at DEPTH, then resume.
    do_reset();
    repeat (10) tick(1'b1, 1'b0, 1'b0, '0);
    check_eq("stall_accepts", acc_log.size(), DEPTH);
    if (acc_log.size() >= 2) begin
      check_eq("stall_addr0", acc_log[0], 32'h0);
      check_eq("stall_addr1", acc_log[1], 32'h4);
    end
    check_eq("stall_req_low", last_req, 1'b0);
    check_eq("stall_head_pc", instr_pc, 32'h0);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      done = (acc_log.size() >= 3);
    end
    check_eq("resume_seen", done, 1'b1);
    if (done) begin
      check_eq("resume_addr", acc_log[2], 32'h8);
      check_eq("resume_del0", del_log.size() >= 1 ? del_log[0] : 32'hDEAD_BEEF, 32'h0);
      check_eq("resume_del1", del_log.size() >= 2 ? del_log[1] : 32'hDEAD_BEEF, 32'h4);
    end

    // Redirect with two reads outstanding: both responses dropped.
    do_reset();
    lat_min = 4; lat_max = 4;
    tick(1'b1, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 1'b0, '0);
    check_eq("redir_outstanding", acc_log.size(), 2);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      done = last_req;
    end
    check_eq("redir_req_seen", done, 1'b1);
    check_eq("redir_target", prev_addr, 32'h0000_0100);
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      done = (del_log.size() >= 1);
    end
    check_eq("redir_deliver_seen", done, 1'b1);
    check_eq("redir_first_pc", del_log.size() >= 1 ? del_log[0] : 32'hDEAD_BEEF, 32'h0000_0100);

    // Grant withheld: request and address held; then reset with a full buffer.
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      check_eq("nogrant_req", last_req, 1'b1);
      check_eq("nogrant_addr", prev_addr, 32'h0);
    end
    repeat (6) tick(1'b1, 1'b0, 1'b0, '0);
    check_eq("full_valid", instr_valid, 1'b1);
    check_eq("full_req_low", mem_req, 1'b0);
    do_reset();
    tick(1'b1, 1'b1, 1'b0, '0);
    check_eq("restart_req", last_req, 1'b1);
    check_eq("restart_addr", prev_addr, A_RESET_PC);

    // Randomized traffic: grants, consumer stalls, latencies, redirects, stray responses.
    do_reset();
    data_key = 32'hC0DE_0000; lat_min = 1; lat_max = 4; spurious_en = 1'b1;
    last_redir = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = !last_redir && ($urandom_range(0, 19) == 0);
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, r, $urandom);
      last_redir = r;
    end
    check_eq("random_progress", del_log.size() > 200, 1'b1);
    check_eq("b_deliveries", b_n >= 3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
